cpu_run_ctrl: RTL and testbench
===============================

CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 Parameter NCPU, default 2, number of CPU instances controlled (1..8); CPU_W = max(1,clog2(NCPU)).
REQ-002 Parameter ADDR_W, default 16, per-CPU word-address width.
REQ-003 Parameter CYC_W, default 32, cycle-counter and timeout width.
REQ-004 Parameter DUMP_WORDS, default 1024, words dumped per CPU (1..2^ADDR_W).
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 start  in  1  one-cycle run/advance request.
REQ-008 run_mask  in  NCPU  CPUs taking part in the run; sampled when leaving IDLE.
REQ-009 timeout_cycles  in  CYC_W  run cycle limit; 0 = unlimited; sampled when leaving IDLE.
REQ-010 ld_valid / ld_ready  in/out  1/1  program-load handshake; a word transfers when both are high.
REQ-011 ld_addr  in  CPU_W+ADDR_W  {cpu index, word address} of load word.
REQ-012 ld_data  in  32  load word.
REQ-013 cpu_rst_n  out  NCPU  per-CPU active-low reset to the CPU instances.
REQ-014 cpu_halt  in  NCPU  per-CPU halt indication.
REQ-015 mem_we  out  1  memory-fabric write strobe (IMEM and DMEM of the addressed CPU).
REQ-016 mem_re  out  1  memory-fabric read strobe; data returns on mem_rdata exactly 1 cycle later.
REQ-017 mem_addr  out  CPU_W+ADDR_W  {cpu index, word address} for load or dump.
REQ-018 mem_wdata  out  32  write data.
REQ-019 mem_rdata  in  32  read data.
REQ-020 dump_valid / dump_ready  out/in  1/1  dump stream handshake.
REQ-021 dump_addr  out  CPU_W+ADDR_W  {cpu index, word address} of dump_data.
REQ-022 dump_data  out  32  dumped word.
REQ-023 done, timed_out  out  1/1  run complete; run ended by timeout rather than halt.
REQ-024 cycles  out  CYC_W  cycles spent in RUN for the current/last run.

Function
REQ-025 States IDLE, RUN, DUMP, DONE; after reset, IDLE.
REQ-026 IDLE: cpu_rst_n all 0, ld_ready = 1; each load transfer drives mem_we = 1, mem_addr = ld_addr, mem_wdata = ld_data in the same cycle (combinational pass-through, zero latency); start moves to RUN, clears cycles and timed_out, and latches run_mask and timeout_cycles.
REQ-027 If start and ld_valid are both high in IDLE, the load word is written and the state still moves to RUN.
REQ-028 RUN: ld_ready = 0; cpu_rst_n[i] = run_mask[i]; cycles increments by 1 every RUN cycle and saturates at all-ones; start is ignored.
REQ-029 RUN: halted[i] is set when cpu_halt[i] & run_mask[i]; it is sticky until the next IDLE->RUN transition.
REQ-030 RUN exits to DUMP in the cycle after all masked CPUs are halted, or after cycles == timeout_cycles (nonzero); timed_out = 1 only in the timeout case, and halt completion wins when both conditions occur in the same cycle.
REQ-031 run_mask == 0: RUN lasts exactly 1 cycle, then moves to DUMP.
REQ-032 DUMP: cpu_rst_n all 0 (CPUs frozen); masked CPUs are walked in ascending index, address 0..DUMP_WORDS-1 each, unmasked CPUs are skipped; mem_re is issued only when the single output buffer is empty or is being consumed in the same cycle; no word is dropped or duplicated under any dump_ready pattern.
REQ-033 dump_valid, dump_addr and dump_data stay stable while dump_valid & !dump_ready.
REQ-034 After the last word is accepted, move to DONE: done = 1; cycles and timed_out are held; a start in DONE returns to IDLE with done cleared.

Reset
REQ-035 rst overrides everything in the same edge, including mid-RUN and mid-DUMP: state = IDLE, cpu_rst_n = 0, done = timed_out = 0, cycles = 0, dump_valid = 0, mem_we = mem_re = 0, halted = 0; buffered dump data is discarded.

Structure
REQ-036 A shared package cpu_run_pkg holds the state enum and the default parameter constants.
REQ-037 The dump output buffer is a sub-module, run_skid_buf (1-entry, valid/ready, 32+CPU_W+ADDR_W bits).

Verification
REQ-038 Load 4 words to CPU1 addr 0..3, start; CPU0/1 halt at cycles 10/25, mask 2'b11 -> RUN exits, cycles = 25, timed_out = 0, done = 1 after the dump.
REQ-039 timeout_cycles = 100, no halt -> timed_out = 1, cycles = 100; halt and timeout in the same cycle -> timed_out = 0.
REQ-040 DUMP_WORDS = 8, mask 2'b10, dump_ready toggling every cycle -> exactly 8 words with dump_addr {1,0}..{1,7} in order, stable while stalled.
REQ-041 rst asserted in the middle of DUMP -> next cycle IDLE, dump_valid = 0, cpu_rst_n = 0, ld_ready = 1.
REQ-042 start during RUN and ld_valid during RUN -> ignored, ld_ready = 0, no mem_we; run_mask = 0 -> DONE with an empty dump.

Source files
------------

// File: rtl/cpu_run_pkg.sv
// Shared types and default constants for the CPU run controller.
package cpu_run_pkg;

  localparam int DEF_NCPU       = 2;
  localparam int DEF_ADDR_W     = 16;
  localparam int DEF_CYC_W      = 32;
  localparam int DEF_DUMP_WORDS = 1024;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DUMP = 2'd2,
    ST_DONE = 2'd3
  } run_state_e;

  // Width of a CPU index; a single CPU still gets one bit.
  function automatic int cpu_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Control, program-load, memory-fabric and dump bus of the CPU run controller.
interface cpu_run_ctrl_if
  import cpu_run_pkg::*;
#(
  parameter int NCPU   = DEF_NCPU,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CYC_W  = DEF_CYC_W
);
  localparam int CPU_W = cpu_width(NCPU);
  localparam int MA_W  = CPU_W + ADDR_W;

  logic              start;
  logic [NCPU-1:0]   run_mask;
  logic [CYC_W-1:0]  timeout_cycles;
  logic              ld_valid;
  logic              ld_ready;
  logic [MA_W-1:0]   ld_addr;
  logic [31:0]       ld_data;
  logic [NCPU-1:0]   cpu_rst_n;
  logic [NCPU-1:0]   cpu_halt;
  logic              mem_we;
  logic              mem_re;
  logic [MA_W-1:0]   mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              dump_valid;
  logic              dump_ready;
  logic [MA_W-1:0]   dump_addr;
  logic [31:0]       dump_data;
  logic              done;
  logic              timed_out;
  logic [CYC_W-1:0]  cycles;

  modport master (
    input  start, run_mask, timeout_cycles, ld_valid, ld_addr, ld_data,
           cpu_halt, mem_rdata, dump_ready,
    output ld_ready, cpu_rst_n, mem_we, mem_re, mem_addr, mem_wdata,
           dump_valid, dump_addr, dump_data, done, timed_out, cycles
  );

  modport slave (
    output start, run_mask, timeout_cycles, ld_valid, ld_addr, ld_data,
           cpu_halt, mem_rdata, dump_ready,
    input  ld_ready, cpu_rst_n, mem_we, mem_re, mem_addr, mem_wdata,
           dump_valid, dump_addr, dump_data, done, timed_out, cycles
  );

endinterface

// File: rtl/cpu_run_ctrl_skid_buf.sv
// One-entry valid/ready output buffer holding a dumped word and its address.
module run_skid_buf #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_q;
  logic [W-1:0] data_q;

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  // Occupancy: fill on an accepted load, drain when the consumer takes the word.
  always_ff @(posedge clk) begin
    if (rst)
      valid_q <= 1'b0;
    else if (in_valid && in_ready)
      valid_q <= 1'b1;
    else if (out_ready)
      valid_q <= 1'b0;
  end

  // Payload only changes on a load, so it stays put while the consumer stalls.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready)
      data_q <= in_data;
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller: loads programs, releases CPUs for a run, then dumps their memories.
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int NCPU       = DEF_NCPU,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int CYC_W      = DEF_CYC_W,
  parameter int DUMP_WORDS = DEF_DUMP_WORDS
) (
  input  logic           clk,
  input  logic           rst,
  cpu_run_ctrl_if.master bus
);

  localparam int CPU_W = cpu_width(NCPU);
  localparam int MA_W  = CPU_W + ADDR_W;
  localparam int BUF_W = MA_W + 32;
  localparam logic [CPU_W-1:0]  LAST_CPU  = CPU_W'(NCPU - 1);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DUMP_WORDS - 1);

  run_state_e state, state_nxt;

  logic [NCPU-1:0]   mask_q, halted_q, halted_now;
  logic [CYC_W-1:0]  timeout_q, cycles_q, cyc_inc;
  logic              timed_out_q;
  logic              all_halted, timeout_hit;

  logic [CPU_W-1:0]  dump_cpu;
  logic [ADDR_W-1:0] dump_word;
  logic              walk_done, rd_pend;
  logic [MA_W-1:0]   rd_addr_q;
  logic              in_dump, skip_cpu, issue_rd, step_cpu;
  logic              buf_valid, buf_in_ready;
  logic [BUF_W-1:0]  buf_out;

  assign halted_now  = halted_q | (bus.cpu_halt & mask_q);
  assign all_halted  = (halted_now == mask_q);
  assign cyc_inc     = (&cycles_q) ? cycles_q : cycles_q + CYC_W'(1);
  assign timeout_hit = (timeout_q != '0) && (cyc_inc == timeout_q);

  // A read may only be launched when nothing is in flight and the buffer will
  // have room for the returning word; unmasked CPUs are skipped one per cycle.
  assign in_dump  = (state == ST_DUMP) && !walk_done && !rst;
  assign skip_cpu = in_dump && !mask_q[dump_cpu];
  assign issue_rd = in_dump && mask_q[dump_cpu] && !rd_pend && buf_in_ready;
  assign step_cpu = skip_cpu || (issue_rd && (dump_word == LAST_WORD));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decision; halt completion is checked before timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.start) state_nxt = ST_RUN;
      ST_RUN:  if (all_halted || timeout_hit) state_nxt = ST_DUMP;
      ST_DUMP: if (walk_done && !rd_pend && (!buf_valid || bus.dump_ready))
                 state_nxt = ST_DONE;
      ST_DONE: if (bus.start) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Run bookkeeping: latch run setup, count RUN cycles, record halts and timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q      <= '0;
      timeout_q   <= '0;
      cycles_q    <= '0;
      timed_out_q <= 1'b0;
      halted_q    <= '0;
    end else if (state == ST_IDLE && bus.start) begin
      mask_q      <= bus.run_mask;
      timeout_q   <= bus.timeout_cycles;
      cycles_q    <= '0;
      timed_out_q <= 1'b0;
      halted_q    <= '0;
    end else if (state == ST_RUN) begin
      cycles_q <= cyc_inc;
      halted_q <= halted_now;
      if (!all_halted && timeout_hit)
        timed_out_q <= 1'b1;
    end
  end

  // Dump walker: CPU/word address generator and the one-deep read pipeline.
  always_ff @(posedge clk) begin
    if (rst || state == ST_RUN) begin
      dump_cpu  <= '0;
      dump_word <= '0;
      walk_done <= 1'b0;
      rd_pend   <= 1'b0;
      rd_addr_q <= '0;
    end else if (state == ST_DUMP) begin
      rd_pend <= issue_rd;
      if (issue_rd)
        rd_addr_q <= {dump_cpu, dump_word};
      if (step_cpu) begin
        dump_word <= '0;
        if (dump_cpu == LAST_CPU) walk_done <= 1'b1;
        else                      dump_cpu  <= dump_cpu + CPU_W'(1);
      end else if (issue_rd) begin
        dump_word <= dump_word + ADDR_W'(1);
      end
    end
  end

  run_skid_buf #(.W(BUF_W)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_pend),
    .in_ready  (buf_in_ready),
    .in_data   ({rd_addr_q, bus.mem_rdata}),
    .out_valid (buf_valid),
    .out_ready (bus.dump_ready),
    .out_data  (buf_out)
  );

  // Outputs: load pass-through in IDLE, CPU resets in RUN, dump stream from the buffer.
  always_comb begin
    bus.ld_ready   = (state == ST_IDLE) && !rst;
    bus.mem_we     = (state == ST_IDLE) && !rst && bus.ld_valid;
    bus.mem_re     = issue_rd;
    bus.mem_addr   = issue_rd ? {dump_cpu, dump_word} : bus.ld_addr;
    bus.mem_wdata  = bus.ld_data;
    bus.cpu_rst_n  = (state == ST_RUN) ? mask_q : '0;
    bus.dump_valid = buf_valid;
    bus.dump_addr  = buf_out[BUF_W-1:32];
    bus.dump_data  = buf_out[31:0];
    bus.done       = (state == ST_DONE);
    bus.timed_out  = timed_out_q;
    bus.cycles     = cycles_q;
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: load/start vector table plus run, timeout, dump and reset sequences.
module tb_cpu_run_ctrl;

  localparam int NCPU = 2;
  localparam int ADDR_W = 16;
  localparam int CYC_W = 32;
  localparam int DUMP_WORDS = 8;
  localparam int MA_W = 1 + ADDR_W;

  typedef struct {
    logic            start;
    logic            ld_valid;
    logic [MA_W-1:0] ld_addr;
    logic [31:0]     ld_data;
    logic [1:0]      run_mask;
    logic [31:0]     timeout;
    logic            exp_ld_ready;
    logic            exp_mem_we;
    logic [1:0]      exp_cpu_rst_n;
    logic [31:0]     exp_cycles;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  logic [31:0]     fab [0:1][0:15];
  logic [31:0]     exp_mem [0:1][0:15];
  logic [MA_W-1:0] exp_addr_q[$];
  logic [31:0]     exp_data_q[$];
  vec_t            vecs [7];

  cpu_run_ctrl_if #(.NCPU(NCPU), .ADDR_W(ADDR_W), .CYC_W(CYC_W)) bus ();

  cpu_run_ctrl #(.NCPU(NCPU), .ADDR_W(ADDR_W), .CYC_W(CYC_W), .DUMP_WORDS(DUMP_WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] initWord(input int c, input int a);
    return 32'hC0DE_0000 | 32'(c << 8) | 32'(a);
  endfunction

  // Memory fabric model: write strobe stores, read strobe returns one cycle later.
  always @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < 2; c++)
        for (int a = 0; a < 16; a++)
          fab[c][a] <= initWord(c, a);
    end else begin
      if (bus.mem_we) fab[bus.mem_addr[ADDR_W]][bus.mem_addr[3:0]] <= bus.mem_wdata;
      if (bus.mem_re) bus.mem_rdata <= fab[bus.mem_addr[ADDR_W]][bus.mem_addr[3:0]];
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic boundFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: wait bound expired", name);
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.start          = v.start;
    bus.ld_valid       = v.ld_valid;
    bus.ld_addr        = v.ld_addr;
    bus.ld_data        = v.ld_data;
    bus.run_mask       = v.run_mask;
    bus.timeout_cycles = v.timeout;
  endtask

  task automatic waitForCycles(input int target);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.cycles == 32'(target)) return;
    end
    boundFail("wait_cycles");
  endtask

  task automatic startRun(input logic [1:0] mask, input int timeout);
    bus.run_mask       = mask;
    bus.timeout_cycles = 32'(timeout);
    bus.start          = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic buildExp(input logic [1:0] mask);
    exp_addr_q.delete();
    exp_data_q.delete();
    for (int c = 0; c < 2; c++)
      if (mask[c])
        for (int a = 0; a < DUMP_WORDS; a++) begin
          exp_addr_q.push_back({1'(c), 16'(a)});
          exp_data_q.push_back(exp_mem[c][a]);
        end
  endtask

  // toggle=0: always ready; toggle=1: dump_ready alternates every cycle.
  task automatic runDump(input bit toggle);
    int idx = 0;
    bit stalled = 1'b0;
    bit got_done = 1'b0;
    logic [MA_W-1:0] prev_addr = '0;
    logic [31:0] prev_data = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      bus.dump_ready = toggle ? 1'(cyc & 1) : 1'b1;
      #1;
      if (stalled) begin
        checkOutput("stall_valid", 64'(bus.dump_valid), 64'd1);
        checkOutput("stall_addr", 64'(bus.dump_addr), 64'(prev_addr));
        checkOutput("stall_data", 64'(bus.dump_data), 64'(prev_data));
      end
      if (bus.dump_valid && bus.dump_ready) begin
        if (idx < exp_addr_q.size()) begin
          checkOutput("dump_addr", 64'(bus.dump_addr), 64'(exp_addr_q[idx]));
          checkOutput("dump_data", 64'(bus.dump_data), 64'(exp_data_q[idx]));
        end else begin
          checkOutput("dump_extra", 64'(idx), 64'(exp_addr_q.size() - 1));
        end
        idx++;
      end
      stalled   = bus.dump_valid && !bus.dump_ready;
      prev_addr = bus.dump_addr;
      prev_data = bus.dump_data;
      if (bus.done) begin
        got_done = 1'b1;
        break;
      end
    end
    if (!got_done) boundFail("dump_done");
    checkOutput("dump_count", 64'(idx), 64'(exp_addr_q.size()));
    bus.dump_ready = 1'b1;
  endtask

  task automatic goIdle();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    checkOutput("idle_done", 64'(bus.done), 64'd0);
    checkOutput("idle_ld_ready", 64'(bus.ld_ready), 64'd1);
  endtask

  initial begin
    int waited;
    rst = 1'b1;
    bus.start = 1'b0; bus.ld_valid = 1'b1; bus.ld_addr = '0; bus.ld_data = '0;
    bus.run_mask = '0; bus.timeout_cycles = '0; bus.cpu_halt = '0; bus.dump_ready = 1'b1;
    for (int c = 0; c < 2; c++)
      for (int a = 0; a < 16; a++)
        exp_mem[c][a] = initWord(c, a);

    //                start ldv  ld_addr       ld_data         mask   tmo    rdy  we   rst_n  cycles
    vecs[0] = '{1'b0, 1'b1, 17'h1_0000, 32'h1111_0000, 2'b11, 32'd0, 1'b1, 1'b1, 2'b00, 32'd0};
    vecs[1] = '{1'b0, 1'b1, 17'h1_0001, 32'h1111_0001, 2'b11, 32'd0, 1'b1, 1'b1, 2'b00, 32'd0};
    vecs[2] = '{1'b0, 1'b0, 17'h1_0007, 32'hDEAD_BEEF, 2'b11, 32'd0, 1'b1, 1'b0, 2'b00, 32'd0};
    vecs[3] = '{1'b0, 1'b1, 17'h1_0002, 32'h1111_0002, 2'b11, 32'd0, 1'b1, 1'b1, 2'b00, 32'd0};
    vecs[4] = '{1'b1, 1'b1, 17'h1_0003, 32'h1111_0003, 2'b11, 32'd0, 1'b1, 1'b1, 2'b00, 32'd0};
    vecs[5] = '{1'b1, 1'b1, 17'h0_0005, 32'hBAD0_0005, 2'b00, 32'd7, 1'b0, 1'b0, 2'b11, 32'd0};
    vecs[6] = '{1'b0, 1'b0, 17'h0_0000, 32'h0,         2'b00, 32'd0, 1'b0, 1'b0, 2'b11, 32'd1};

    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_mem_we", 64'(bus.mem_we), 64'd0);
    checkOutput("rst_done", 64'(bus.done), 64'd0);
    checkOutput("rst_cpu_rst_n", 64'(bus.cpu_rst_n), 64'd0);
    checkOutput("rst_dump_valid", 64'(bus.dump_valid), 64'd0);
    checkOutput("rst_cycles", 64'(bus.cycles), 64'd0);
    checkOutput("rst_timed_out", 64'(bus.timed_out), 64'd0);
    rst = 1'b0;
    bus.ld_valid = 1'b0;

    $display("[TB] load/start vector table");
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput("vec_ld_ready", 64'(bus.ld_ready), 64'(vecs[i].exp_ld_ready));
      checkOutput("vec_mem_we", 64'(bus.mem_we), 64'(vecs[i].exp_mem_we));
      if (vecs[i].exp_mem_we) begin
        checkOutput("vec_mem_addr", 64'(bus.mem_addr), 64'(vecs[i].ld_addr));
        checkOutput("vec_mem_wdata", 64'(bus.mem_wdata), 64'(vecs[i].ld_data));
        exp_mem[vecs[i].ld_addr[ADDR_W]][vecs[i].ld_addr[3:0]] = vecs[i].ld_data;
      end
      checkOutput("vec_cpu_rst_n", 64'(bus.cpu_rst_n), 64'(vecs[i].exp_cpu_rst_n));
      checkOutput("vec_cycles", 64'(bus.cycles), 64'(vecs[i].exp_cycles));
      checkOutput("vec_done", 64'(bus.done), 64'd0);
    end

    $display("[TB] halt-terminated run, mask 11");
    waitForCycles(9);
    bus.cpu_halt = 2'b01;
    @(negedge clk);
    bus.cpu_halt = 2'b00;
    #1;
    checkOutput("halt0_still_run", 64'(bus.cpu_rst_n), 64'b11);
    waitForCycles(24);
    checkOutput("pre_halt1_run", 64'(bus.cpu_rst_n), 64'b11);
    bus.cpu_halt = 2'b10;
    @(negedge clk);
    #1;
    checkOutput("halt_cycles", 64'(bus.cycles), 64'd25);
    checkOutput("halt_cpu_rst_n", 64'(bus.cpu_rst_n), 64'd0);
    checkOutput("halt_timed_out", 64'(bus.timed_out), 64'd0);
    bus.cpu_halt = 2'b00;
    buildExp(2'b11);
    runDump(1'b0);
    checkOutput("a_done", 64'(bus.done), 64'd1);
    checkOutput("a_cycles_held", 64'(bus.cycles), 64'd25);
    goIdle();

    $display("[TB] timeout run, limit 100");
    startRun(2'b11, 100);
    waited = 0;
    while (bus.cpu_rst_n != 2'b00 && waited < 300) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (waited >= 300) boundFail("timeout_exit");
    checkOutput("to_cycles", 64'(bus.cycles), 64'd100);
    checkOutput("to_timed_out", 64'(bus.timed_out), 64'd1);
    runDump(1'b0);
    checkOutput("to_timed_out_held", 64'(bus.timed_out), 64'd1);
    goIdle();

    $display("[TB] halt and timeout in the same cycle");
    startRun(2'b01, 20);
    waitForCycles(19);
    bus.cpu_halt = 2'b01;
    @(negedge clk);
    #1;
    checkOutput("tie_cycles", 64'(bus.cycles), 64'd20);
    checkOutput("tie_timed_out", 64'(bus.timed_out), 64'd0);
    checkOutput("tie_cpu_rst_n", 64'(bus.cpu_rst_n), 64'd0);
    bus.cpu_halt = 2'b00;
    buildExp(2'b01);
    runDump(1'b1);
    goIdle();

    $display("[TB] mask 10, toggling dump_ready");
    startRun(2'b10, 0);
    #1;
    checkOutput("m10_cpu_rst_n", 64'(bus.cpu_rst_n), 64'b10);
    bus.cpu_halt = 2'b10;
    @(negedge clk);
    bus.cpu_halt = 2'b00;
    #1;
    checkOutput("m10_cycles", 64'(bus.cycles), 64'd1);
    buildExp(2'b10);
    runDump(1'b1);
    goIdle();

    $display("[TB] empty mask");
    startRun(2'b00, 0);
    #1;
    checkOutput("m0_cpu_rst_n", 64'(bus.cpu_rst_n), 64'd0);
    checkOutput("m0_ld_ready", 64'(bus.ld_ready), 64'd0);
    checkOutput("m0_first_cycles", 64'(bus.cycles), 64'd0);
    buildExp(2'b00);
    runDump(1'b0);
    checkOutput("m0_cycles", 64'(bus.cycles), 64'd1);
    checkOutput("m0_done", 64'(bus.done), 64'd1);
    goIdle();

    $display("[TB] reset in the middle of a dump");
    startRun(2'b11, 0);
    bus.cpu_halt = 2'b11;
    @(negedge clk);
    bus.cpu_halt = 2'b00;
    bus.dump_ready = 1'b0;
    waited = 0;
    while (!bus.dump_valid && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (waited >= 20) boundFail("mid_dump_valid");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("mr_dump_valid", 64'(bus.dump_valid), 64'd0);
    checkOutput("mr_cpu_rst_n", 64'(bus.cpu_rst_n), 64'd0);
    checkOutput("mr_ld_ready", 64'(bus.ld_ready), 64'd1);
    checkOutput("mr_done", 64'(bus.done), 64'd0);
    checkOutput("mr_cycles", 64'(bus.cycles), 64'd0);
    checkOutput("mr_mem_re", 64'(bus.mem_re), 64'd0);
    @(negedge clk);
    #1;
    checkOutput("mr_dump_valid_later", 64'(bus.dump_valid), 64'd0);
    checkOutput("mr_ld_ready_later", 64'(bus.ld_ready), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
